rename_ctrl: RTL and testbench

- Sequences the rename stage around the architectural-to-physical map table (32 aregs, 128 pregs, single shadow checkpoint).
- Owns the physical-register free list and the single branch checkpoint token.
- Handshakes decode (upstream) and dispatch (downstream) with valid/ready.
- Drives the map table's write, snapshot and restore controls; registers renamed operands into one output stage.

---
 rtl/rename_pkg.sv | 36 +++
 rtl/rename_ctrl_chk.sv | 14 +
 rtl/rename_ctrl_free_list.sv | 82 ++++++++
 rtl/rename_ctrl.sv | 145 ++++++++++++++
 tb/tb_rename_ctrl.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/rename_pkg.sv
// Shared sizes, index types and the renamed-instruction record for the rename stage.
package rename_pkg;

  localparam int AREG_WIDTH = 5;
  localparam int PREG_WIDTH = 7;
  localparam int CNT_WIDTH  = 7;
  localparam int NUM_AREGS  = 32;
  localparam int NUM_PREGS  = 128;
  localparam int FL_DEPTH   = NUM_PREGS - NUM_AREGS;

  typedef logic [AREG_WIDTH-1:0] areg_t;
  typedef logic [PREG_WIDTH-1:0] preg_t;
  typedef logic [CNT_WIDTH-1:0]  cnt_t;
  typedef logic [6:0]            fl_idx_t;

  typedef struct packed {
    preg_t prs1;
    preg_t prs2;
    preg_t prd;
    preg_t old_prd;
    logic  has_dest;
    logic  is_branch;
  } ren_inst_t;

  // Circular free-list pointers run 0..FL_DEPTH-1 and wrap back to 0.
  function automatic fl_idx_t fl_next(input fl_idx_t idx);
    fl_idx_t nxt;
    if (idx == fl_idx_t'(FL_DEPTH - 1)) begin
      nxt = 7'd0;
    end else begin
      nxt = idx + 7'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/rename_ctrl_chk.sv
// Protocol checker for the rename stage: the ROB must never return a preg to a full free list.
module rename_ctrl_chk
  import rename_pkg::*;
(
  input logic clk,
  input logic reset,
  input logic commit_free_valid,
  input cnt_t free_count
);

  a_no_push_when_full : assert property (@(posedge clk) disable iff (reset)
    !(commit_free_valid && (free_count == cnt_t'(FL_DEPTH))));

endmodule

// File: rtl/rename_ctrl_free_list.sv
// Physical-register free list: circular buffer with head/tail/count and a single
// head checkpoint that a mispredict restores, returning the speculative allocations.
module free_list
  import rename_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  pop,
  input  logic  push,
  input  preg_t push_preg,
  input  logic  ckpt,
  input  logic  restore,
  output preg_t head_preg,
  output cnt_t  count
);

  preg_t   fl_q [FL_DEPTH];
  fl_idx_t head_q, head_d;
  fl_idx_t tail_q, tail_d;
  fl_idx_t head_snap_q, head_snap_d;
  fl_idx_t head_post_pop;
  cnt_t    count_q, count_d;
  cnt_t    alloc_q, alloc_d;
  logic    push_ok;

  // Pointer, count and checkpoint bookkeeping.
  always_comb begin
    push_ok       = push && (count_q != cnt_t'(FL_DEPTH));
    head_post_pop = pop ? fl_next(head_q) : head_q;
    tail_d        = push_ok ? fl_next(tail_q) : tail_q;
    head_d        = head_q;
    head_snap_d   = head_snap_q;
    count_d       = count_q;
    alloc_d       = alloc_q;
    if (restore) begin
      head_d  = head_snap_q;
      count_d = count_q + alloc_q + {6'd0, push_ok};
      alloc_d = 7'd0;
    end else begin
      head_d  = head_post_pop;
      count_d = count_q - {6'd0, pop} + {6'd0, push_ok};
      if (ckpt) begin
        head_snap_d = head_post_pop;
        alloc_d     = 7'd0;
      end else begin
        alloc_d = alloc_q + {6'd0, pop};
      end
    end
  end

  // Pointer and counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_q      <= 7'd0;
      tail_q      <= 7'd0;
      head_snap_q <= 7'd0;
      count_q     <= cnt_t'(FL_DEPTH);
      alloc_q     <= 7'd0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      head_snap_q <= head_snap_d;
      count_q     <= count_d;
      alloc_q     <= alloc_d;
    end
  end

  // Storage: after reset entry i holds preg 32+i, the pregs not mapped at reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < FL_DEPTH; i++) begin
        fl_q[i] <= preg_t'(NUM_AREGS + i);
      end
    end else if (push_ok) begin
      fl_q[tail_q] <= push_preg;
    end
  end

  assign head_preg = fl_q[head_q];
  assign count     = count_q;

endmodule

// File: rtl/rename_ctrl.sv
// Rename stage control: decode/dispatch handshake, map-table control strobes,
// the single branch checkpoint token and the renamed-instruction output register.
module rename_ctrl
  import rename_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  dec_valid,
  output logic                  dec_ready,
  input  logic [AREG_WIDTH-1:0] dec_rs1,
  input  logic [AREG_WIDTH-1:0] dec_rs2,
  input  logic [AREG_WIDTH-1:0] dec_rd,
  input  logic                  dec_reg_write,
  input  logic                  dec_is_branch,
  output logic [AREG_WIDTH-1:0] mt_rs1,
  output logic [AREG_WIDTH-1:0] mt_rs2,
  output logic [AREG_WIDTH-1:0] mt_rd,
  output logic                  mt_reg_write,
  output logic [PREG_WIDTH-1:0] mt_new_preg,
  output logic                  mt_is_branch_dispatch,
  output logic                  mt_branch_mispredict,
  input  logic [PREG_WIDTH-1:0] mt_prs1,
  input  logic [PREG_WIDTH-1:0] mt_prs2,
  input  logic [PREG_WIDTH-1:0] mt_old_p_dest,
  output logic                  ren_valid,
  input  logic                  ren_ready,
  output logic [PREG_WIDTH-1:0] ren_prs1,
  output logic [PREG_WIDTH-1:0] ren_prs2,
  output logic [PREG_WIDTH-1:0] ren_prd,
  output logic [PREG_WIDTH-1:0] ren_old_prd,
  output logic                  ren_has_dest,
  output logic                  ren_is_branch,
  input  logic                  commit_free_valid,
  input  logic [PREG_WIDTH-1:0] commit_free_preg,
  input  logic                  br_resolve_valid,
  input  logic                  br_mispredict,
  output logic [6:0]            free_count
);

  logic      need_dest;
  logic      fire;
  logic      restore;
  logic      ckpt_busy_q, ckpt_busy_d;
  logic      ren_valid_q, ren_valid_d;
  ren_inst_t ren_q, ren_d;
  preg_t     head_preg;
  cnt_t      fl_count;

  // Handshake: a stalled instruction leaves every piece of state untouched.
  always_comb begin
    need_dest = dec_reg_write && (dec_rd != 5'd0);
    restore   = br_resolve_valid && br_mispredict && ckpt_busy_q;
    dec_ready = !reset
             && (!ren_valid_q || ren_ready)
             && !(need_dest && (fl_count == 7'd0))
             && !(dec_is_branch && ckpt_busy_q)
             && !restore;
    fire      = dec_valid && dec_ready;
  end

  // Checkpoint token and output register next state.
  always_comb begin
    ckpt_busy_d = ckpt_busy_q;
    ren_valid_d = ren_valid_q;
    ren_d       = ren_q;
    if (restore) begin
      ckpt_busy_d = 1'b0;
    end else if (br_resolve_valid && ckpt_busy_q) begin
      ckpt_busy_d = 1'b0;
    end else if (fire && dec_is_branch) begin
      ckpt_busy_d = 1'b1;
    end else begin
      ckpt_busy_d = ckpt_busy_q;
    end
    // Anything held in the output register is younger than the mispredicted branch.
    if (restore) begin
      ren_valid_d = 1'b0;
    end else if (fire) begin
      ren_valid_d = 1'b1;
    end else if (ren_ready) begin
      ren_valid_d = 1'b0;
    end else begin
      ren_valid_d = ren_valid_q;
    end
    if (fire) begin
      ren_d.prs1      = mt_prs1;
      ren_d.prs2      = mt_prs2;
      ren_d.prd       = need_dest ? head_preg : 7'd0;
      ren_d.old_prd   = mt_old_p_dest;
      ren_d.has_dest  = need_dest;
      ren_d.is_branch = dec_is_branch;
    end else begin
      ren_d = ren_q;
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      ckpt_busy_q <= 1'b0;
      ren_valid_q <= 1'b0;
      ren_q       <= '0;
    end else begin
      ckpt_busy_q <= ckpt_busy_d;
      ren_valid_q <= ren_valid_d;
      ren_q       <= ren_d;
    end
  end

  free_list u_free_list (
    .clk       (clk),
    .reset     (reset),
    .pop       (fire && need_dest),
    .push      (commit_free_valid),
    .push_preg (commit_free_preg),
    .ckpt      (fire && dec_is_branch),
    .restore   (restore),
    .head_preg (head_preg),
    .count     (fl_count)
  );

  rename_ctrl_chk u_chk (
    .clk               (clk),
    .reset             (reset),
    .commit_free_valid (commit_free_valid),
    .free_count        (fl_count)
  );

  assign mt_rs1                = dec_rs1;
  assign mt_rs2                = dec_rs2;
  assign mt_rd                 = dec_rd;
  assign mt_reg_write          = fire && need_dest;
  assign mt_new_preg           = head_preg;
  assign mt_is_branch_dispatch = fire && dec_is_branch;
  assign mt_branch_mispredict  = restore;
  assign ren_valid             = ren_valid_q;
  assign ren_prs1              = ren_q.prs1;
  assign ren_prs2              = ren_q.prs2;
  assign ren_prd               = ren_q.prd;
  assign ren_old_prd           = ren_q.old_prd;
  assign ren_has_dest          = ren_q.has_dest;
  assign ren_is_branch         = ren_q.is_branch;
  assign free_count            = fl_count;

endmodule

// File: tb/tb_rename_ctrl.sv
// Self-checking bench for rename_ctrl: directed vectors, a behavioural map table,
// and a scoreboard queue drained by an independent dispatch-side monitor.
module tb_rename_ctrl;
  import rename_pkg::*;

  logic clk, reset;
  logic dec_valid, dec_ready;
  logic [4:0] dec_rs1, dec_rs2, dec_rd;
  logic dec_reg_write, dec_is_branch;
  logic [4:0] mt_rs1, mt_rs2, mt_rd;
  logic mt_reg_write, mt_is_branch_dispatch, mt_branch_mispredict;
  logic [6:0] mt_new_preg, mt_prs1, mt_prs2, mt_old_p_dest;
  logic ren_valid, ren_ready;
  logic [6:0] ren_prs1, ren_prs2, ren_prd, ren_old_prd;
  logic ren_has_dest, ren_is_branch;
  logic commit_free_valid;
  logic [6:0] commit_free_preg;
  logic br_resolve_valid, br_mispredict;
  logic [6:0] free_count;

  int checks = 0;
  int passes = 0;
  ren_inst_t sb_q[$];

  preg_t map_q [NUM_AREGS];
  preg_t snap_q [NUM_AREGS];

  rename_ctrl dut (
    .clk(clk), .reset(reset),
    .dec_valid(dec_valid), .dec_ready(dec_ready),
    .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd),
    .dec_reg_write(dec_reg_write), .dec_is_branch(dec_is_branch),
    .mt_rs1(mt_rs1), .mt_rs2(mt_rs2), .mt_rd(mt_rd),
    .mt_reg_write(mt_reg_write), .mt_new_preg(mt_new_preg),
    .mt_is_branch_dispatch(mt_is_branch_dispatch), .mt_branch_mispredict(mt_branch_mispredict),
    .mt_prs1(mt_prs1), .mt_prs2(mt_prs2), .mt_old_p_dest(mt_old_p_dest),
    .ren_valid(ren_valid), .ren_ready(ren_ready),
    .ren_prs1(ren_prs1), .ren_prs2(ren_prs2), .ren_prd(ren_prd), .ren_old_prd(ren_old_prd),
    .ren_has_dest(ren_has_dest), .ren_is_branch(ren_is_branch),
    .commit_free_valid(commit_free_valid), .commit_free_preg(commit_free_preg),
    .br_resolve_valid(br_resolve_valid), .br_mispredict(br_mispredict),
    .free_count(free_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Map table environment: identity at reset, one shadow copy.
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_AREGS; i++) begin
        map_q[i]  <= preg_t'(i);
        snap_q[i] <= preg_t'(i);
      end
    end else if (mt_branch_mispredict) begin
      map_q <= snap_q;
    end else begin
      if (mt_is_branch_dispatch) snap_q <= map_q;
      if (mt_reg_write) map_q[mt_rd] <= mt_new_preg;
    end
  end

  assign mt_prs1       = map_q[mt_rs1];
  assign mt_prs2       = map_q[mt_rs2];
  assign mt_old_p_dest = map_q[mt_rd];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  function automatic ren_inst_t mk(input int p1, input int p2, input int prd, input int old,
                                   input logic hd, input logic br);
    ren_inst_t r;
    r.prs1 = preg_t'(p1); r.prs2 = preg_t'(p2); r.prd = preg_t'(prd);
    r.old_prd = preg_t'(old); r.has_dest = hd; r.is_branch = br;
    return r;
  endfunction

  // Dispatch-side monitor: every handoff is compared with the oldest expectation.
  always @(negedge clk) begin
    if (!reset && ren_valid === 1'b1 && ren_ready === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_ren", 32'd1, 32'd0);
      end else begin
        chk("ren_out", {2'b00, ren_prs1, ren_prs2, ren_prd, ren_old_prd, ren_has_dest, ren_is_branch},
            {2'b00, sb_q.pop_front()});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_dec(input int rs1, input int rs2, input int rd, input logic rw, input logic br);
    dec_valid = 1'b1;
    dec_rs1 = 5'(rs1); dec_rs2 = 5'(rs2); dec_rd = 5'(rd);
    dec_reg_write = rw; dec_is_branch = br;
  endtask

  task automatic rename(input int rs1, input int rs2, input int rd, input logic rw, input logic br,
                        input logic exp_push, input ren_inst_t exp);
    int n;
    set_dec(rs1, rs2, rd, rw, br);
    #1;
    n = 0;
    while (dec_ready !== 1'b1 && n < 20) begin
      tick();
      #1;
      n++;
    end
    chk("rename_accepted", dec_ready, 32'd1);
    if (dec_ready === 1'b1 && exp_push) sb_q.push_back(exp);
    tick();
    dec_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; ren_ready = 1'b1;
    commit_free_valid = 1'b0; commit_free_preg = 7'd0;
    br_resolve_valid = 1'b0; br_mispredict = 1'b0;
    set_dec(1, 2, 5, 1'b1, 1'b0);
    repeat (3) tick();
    chk("dec_ready_in_reset", dec_ready, 32'd0);
    chk("ren_valid_in_reset", ren_valid, 32'd0);
    chk("count_in_reset", free_count, 32'd96);
    dec_valid = 1'b0; reset = 1'b0;
    tick();
    chk("ren_prd_after_reset", ren_prd, 32'd0);

    // First allocation takes preg 32
    set_dec(1, 2, 5, 1'b1, 1'b0); #1;
    chk("mt_new_preg_first", mt_new_preg, 32'd32);
    chk("mt_reg_write_first", mt_reg_write, 32'd1);
    rename(1, 2, 5, 1'b1, 1'b0, 1'b1, mk(1, 2, 32, 5, 1'b1, 1'b0));
    chk("count_after_first", free_count, 32'd95);

    // x0 destination allocates nothing
    set_dec(5, 3, 0, 1'b1, 1'b0); #1;
    chk("mt_reg_write_x0", mt_reg_write, 32'd0);
    rename(5, 3, 0, 1'b1, 1'b0, 1'b1, mk(32, 3, 0, 0, 1'b0, 1'b0));
    chk("count_after_x0", free_count, 32'd95);

    // Exhaust the free list
    for (int k = 0; k < 95; k++) begin
      rename(0, 0, 6, 1'b1, 1'b0, 1'b1, mk(0, 0, 33 + k, (k == 0) ? 6 : 32 + k, 1'b1, 1'b0));
    end
    chk("count_empty", free_count, 32'd0);
    set_dec(0, 0, 7, 1'b1, 1'b0); #1;
    chk("dec_ready_empty", dec_ready, 32'd0);
    tick();
    chk("count_stall_empty", free_count, 32'd0);
    dec_valid = 1'b0;
    commit_free_valid = 1'b1; commit_free_preg = 7'd40;
    tick();
    commit_free_valid = 1'b0;
    chk("count_one_commit", free_count, 32'd1);
    rename(0, 0, 7, 1'b1, 1'b0, 1'b1, mk(0, 0, 40, 7, 1'b1, 1'b0));
    chk("count_reempty", free_count, 32'd0);
    for (int i = 0; i < 90; i++) begin
      commit_free_valid = 1'b1; commit_free_preg = 7'(33 + i);
      tick();
    end
    commit_free_valid = 1'b0;
    chk("count_refill", free_count, 32'd90);

    // Mispredict restore
    set_dec(1, 2, 0, 1'b0, 1'b1); #1;
    chk("mt_snapshot", mt_is_branch_dispatch, 32'd1);
    rename(1, 2, 0, 1'b0, 1'b1, 1'b1, mk(1, 2, 0, 0, 1'b0, 1'b1));
    rename(0, 0, 8, 1'b1, 1'b0, 1'b1, mk(0, 0, 33, 8, 1'b1, 1'b0));
    rename(0, 0, 9, 1'b1, 1'b0, 1'b1, mk(0, 0, 34, 9, 1'b1, 1'b0));
    tick();
    ren_ready = 1'b0;
    rename(0, 0, 10, 1'b1, 1'b0, 1'b0, mk(0, 0, 35, 10, 1'b1, 1'b0));
    chk("count_before_restore", free_count, 32'd87);
    chk("ren_valid_before_restore", ren_valid, 32'd1);
    br_resolve_valid = 1'b1; br_mispredict = 1'b1;
    commit_free_valid = 1'b1; commit_free_preg = 7'd100;
    #1;
    chk("mt_mispredict_pulse", mt_branch_mispredict, 32'd1);
    chk("dec_ready_restore", dec_ready, 32'd0);
    tick();
    commit_free_valid = 1'b0;
    chk("count_after_restore", free_count, 32'd91);
    chk("ren_valid_after_restore", ren_valid, 32'd0);
    chk("head_restored", mt_new_preg, 32'd33);
    chk("mt_mispredict_one_cycle", mt_branch_mispredict, 32'd0);
    tick();
    chk("count_resolve_no_ckpt", free_count, 32'd91);
    br_resolve_valid = 1'b0; br_mispredict = 1'b0; ren_ready = 1'b1;

    // Second branch blocked until a correct resolve
    rename(1, 2, 0, 1'b0, 1'b1, 1'b1, mk(1, 2, 0, 0, 1'b0, 1'b1));
    set_dec(8, 9, 0, 1'b0, 1'b1); #1;
    chk("branch_blocked_a", dec_ready, 32'd0);
    tick();
    chk("branch_blocked_b", dec_ready, 32'd0);
    br_resolve_valid = 1'b1; br_mispredict = 1'b0; #1;
    chk("branch_blocked_resolve", dec_ready, 32'd0);
    chk("no_restore_correct", mt_branch_mispredict, 32'd0);
    tick();
    br_resolve_valid = 1'b0; #1;
    chk("branch_after_resolve", dec_ready, 32'd1);
    rename(8, 9, 0, 1'b0, 1'b1, 1'b1, mk(8, 9, 0, 0, 1'b0, 1'b1));
    br_resolve_valid = 1'b1; br_mispredict = 1'b0;
    rename(0, 0, 11, 1'b1, 1'b0, 1'b1, mk(0, 0, 33, 11, 1'b1, 1'b0));
    br_resolve_valid = 1'b0;
    chk("count_resolve_fire", free_count, 32'd90);
    dec_is_branch = 1'b1; #1;
    chk("ckpt_cleared", dec_ready, 32'd1);
    dec_is_branch = 1'b0;
    tick();

    // Back-pressure, then reset mid-stall
    ren_ready = 1'b0;
    rename(0, 0, 12, 1'b1, 1'b0, 1'b0, mk(0, 0, 34, 12, 1'b1, 1'b0));
    chk("stall_ren_valid", ren_valid, 32'd1);
    chk("stall_ren_prd", ren_prd, 32'd34);
    chk("stall_count", free_count, 32'd89);
    set_dec(0, 0, 13, 1'b1, 1'b0); #1;
    chk("stall_dec_ready", dec_ready, 32'd0);
    repeat (2) tick();
    chk("stall_prd_stable", ren_prd, 32'd34);
    chk("stall_old_stable", ren_old_prd, 32'd12);
    chk("stall_no_pop", free_count, 32'd89);
    chk("stall_no_write", mt_reg_write, 32'd0);
    reset = 1'b1; #1;
    chk("dec_ready_mid_reset", dec_ready, 32'd0);
    tick();
    reset = 1'b0; dec_valid = 1'b0;
    chk("reset_ren_valid", ren_valid, 32'd0);
    chk("reset_ren_prd", ren_prd, 32'd0);
    chk("reset_ren_old", ren_old_prd, 32'd0);
    chk("reset_count", free_count, 32'd96);
    chk("reset_head", mt_new_preg, 32'd32);
    ren_ready = 1'b1;
    rename(1, 2, 5, 1'b1, 1'b0, 1'b1, mk(1, 2, 32, 5, 1'b1, 1'b0));
    repeat (2) tick();
    chk("scoreboard_drained", sb_q.size(), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
